ahb_resp_mux_decoder: RTL
=========================

Name: ahb_resp_mux_decoder

Overview:
- Parametrised AHB-Lite interconnect slice between the DMAC master port and N slave peripherals. Generalises the hard-wired 2-slave select/latched-select/HREADY mux used around the DMAC.
- Decodes the address phase into one-hot HSEL and registers the data-phase owner. Muxes HRDATA/HREADY/HRESP back to the master.
- Adds an ERROR-returning default slave for unmapped addresses, a per-transfer wait-state watchdog, and an error counter.

Parameters:
- NUM_SLAVES, 2, number of slave ports (1..8)
- DATA_W, 32, data bus width
- DEC_LSB, 28, lowest HADDR bit of the region field
- DEC_W, 4, width of the region field HADDR[DEC_LSB+DEC_W-1:DEC_LSB]
- REGION_MAP, {4'h0,4'h1}, packed NUM_SLAVES*DEC_W; slice i is the region value for slave i
- TIMEOUT, 64, max consecutive wait states before a forced ERROR; 0 disables the watchdog
- CNT_W, 16, width of err_cnt

Ports:
- clk, in, 1, clock
- rst, in, 1, reset: synchronous, active-high
- HADDR, in, 32, master address
- HTRANS, in, 2, master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- HSEL, out, NUM_SLAVES, one-hot address-phase select
- S_HRDATA, in, NUM_SLAVES*DATA_W, slave read data; slice i belongs to slave i
- S_HREADYOUT, in, NUM_SLAVES, slave ready
- S_HRESP, in, NUM_SLAVES*2, slave response (00 OKAY, 01 ERROR)
- HREADY, out, 1, ready to master and to all slaves' HREADYIN
- HRDATA, out, DATA_W, read data to master
- HRESP, out, 2, response to master
- to_clr, in, 1, clears timeout_flag
- timeout_flag, out, 1, sticky watchdog-fired flag
- timeout_addr, out, 32, data-phase address of the transfer that timed out
- err_cnt, out, CNT_W, saturating count of completed ERROR responses

Behaviour:
- Decode (comb): HSEL[i]=1 for the lowest i whose REGION_MAP slice equals the region field. All zero if no match (unmapped). HSEL is independent of HTRANS.
- Data-phase register: on a clk edge with HREADY=1, capture dsel (decoded slave index, or DEFAULT if unmapped), dact=HTRANS[1] and daddr=HADDR. Hold while HREADY=0.
- Reset: dsel=DEFAULT, dact=0, FSM=IDLE, wd_cnt=0, timeout_flag=0, timeout_addr=0, err_cnt=0. Outputs after reset: HREADY=1, HRDATA=0, HRESP=00.
- FSM states: IDLE, PASS, DERR1, DERR2, TO1, TO2.
- From IDLE, PASS, DERR2 or TO2, on a HREADY=1 edge:
  - unmapped with NONSEQ/SEQ -> DERR1
  - mapped -> PASS
  - unmapped IDLE/BUSY -> IDLE
- PASS:
  - HREADY=S_HREADYOUT[dsel], HRDATA=S_HRDATA[dsel], HRESP=S_HRESP[dsel]. Pass-through is zero-latency combinational.
  - If dact=1, HREADY=0 and wd_cnt==TIMEOUT-1 (TIMEOUT!=0), go to TO1.
- IDLE: HREADY=1, HRESP=00, HRDATA=0.
- DERR1: HREADY=0, HRESP=01, go to DERR2. DERR2: HREADY=1, HRESP=01.
- TO1: HREADY=0, HRESP=01; set timeout_flag and load timeout_addr=daddr; go to TO2. TO2: HREADY=1, HRESP=01.
  - Any late response from the stalled slave is ignored: the mux follows the new dsel after TO2.
- wd_cnt: increments each cycle in PASS with dact=1 and HREADY=0. Clears on any HREADY=1 cycle and on entry to TO1. Timeout fires exactly TIMEOUT wait cycles after the data phase starts.
- err_cnt: increments on every cycle with HREADY=1 and HRESP=01 (slave, default, or timeout error). Saturates at all-ones.
- to_clr clears timeout_flag next edge; if a TO1 entry coincides with to_clr, set wins. timeout_addr holds until the next timeout.
- Back-to-back transfers: a new address phase is accepted on the same edge that completes the previous data phase (pipelined, no bubble).
- rst asserted mid-wait or mid-error: all state returns to reset values on that edge. A stalled slave's HREADYOUT is then ignored until a new mapped address phase completes.

Test Plan:
- Reset, then NONSEQ read to 0x0000_0010 with slave1 zero-wait, S_HRDATA=0xA5A5_0001 -> HSEL=2'b10; next cycle HRDATA=0xA5A5_0001, HREADY=1, HRESP=00.
- NONSEQ to 0x1000_0000 followed by SEQ to 0x0000_0004, back-to-back -> HSEL toggles 01 then 10; data phases are muxed from slave0 then slave1 with no idle cycle.
- NONSEQ to 0x2000_0000 (unmapped) -> HREADY=0/HRESP=01, then HREADY=1/HRESP=01; err_cnt=1. An IDLE to the same address gives OKAY, zero wait.
- Slave0 holds HREADYOUT=0 with TIMEOUT=4 on addr 0x1000_0008 -> 4 wait cycles, TO1, TO2; timeout_flag=1, timeout_addr=0x1000_0008; to_clr pulse clears the flag.
- Slave1 returns the two-cycle ERROR 0xFFFF times, then once more -> err_cnt stays 0xFFFF (saturation).
- rst asserted during TO1 -> next cycle HREADY=1, HRESP=00, timeout_flag=0, err_cnt=0.

Source files
------------

// File: rtl/ahb_resp_mux_decoder.sv
// ahb_resp_mux_decoder
//   AHB-Lite interconnect slice between one master (the DMAC) and NUM_SLAVES
//   peripherals. Decodes the address phase into a one-hot HSEL, registers the
//   data-phase owner and muxes HRDATA/HREADY/HRESP back to the master. An
//   internal default slave answers unmapped NONSEQ/SEQ transfers with the
//   two-cycle ERROR response. A watchdog forces an ERROR if a slave inserts
//   TIMEOUT consecutive wait states. Completed ERROR responses are counted.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   HADDR, HTRANS     master address phase
//   HSEL              one-hot slave select (address phase, comb)
//   S_HRDATA          slave read data, slice i = slave i
//   S_HREADYOUT       slave ready, bit i = slave i
//   S_HRESP           slave response, 2-bit slice i = slave i
//   HREADY            ready to master and to every slave's HREADYIN
//   HRDATA, HRESP     data-phase response to master
//   to_clr            clears timeout_flag
//   timeout_flag      sticky watchdog-fired flag
//   timeout_addr      data-phase address of the transfer that timed out
//   err_cnt           saturating count of completed ERROR responses
//   dbg_state         current FSM state (debug)
//
// Handshake: an address phase is accepted, and the current data phase
// completes, on every clk edge where HREADY=1. While HREADY=0 the master
// holds its address phase and the registered data-phase owner is frozen.
module ahb_resp_mux_decoder #(
    parameter int                          NUM_SLAVES = 2,
    parameter int                          DATA_W     = 32,
    parameter int                          DEC_LSB    = 28,
    parameter int                          DEC_W      = 4,
    parameter logic [NUM_SLAVES*DEC_W-1:0] REGION_MAP = {4'h0, 4'h1},
    parameter int                          TIMEOUT    = 64,
    parameter int                          CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  HADDR,
    input  logic [1:0]                   HTRANS,
    output logic [NUM_SLAVES-1:0]        HSEL,
    input  logic [NUM_SLAVES*DATA_W-1:0] S_HRDATA,
    input  logic [NUM_SLAVES-1:0]        S_HREADYOUT,
    input  logic [NUM_SLAVES*2-1:0]      S_HRESP,
    output logic                         HREADY,
    output logic [DATA_W-1:0]            HRDATA,
    output logic [1:0]                   HRESP,
    input  logic                         to_clr,
    output logic                         timeout_flag,
    output logic [31:0]                  timeout_addr,
    output logic [CNT_W-1:0]             err_cnt,
    output logic [2:0]                   dbg_state
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PASS  = 3'd1,
        ST_DERR1 = 3'd2,
        ST_DERR2 = 3'd3,
        ST_TO1   = 3'd4,
        ST_TO2   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  dsel_q, dsel_d;
    logic              dact_q, dact_d;
    logic [31:0]       daddr_q, daddr_d;
    logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic              to_flag_q, to_flag_d;
    logic [31:0]       to_addr_q, to_addr_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic              dec_hit;
    logic [SEL_W-1:0]  dec_idx;
    logic              wd_fire;
    state_t            accept_state;

    // Address decode: lowest matching slave wins, independent of HTRANS.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        HSEL    = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!dec_hit && (REGION_MAP[i*DEC_W +: DEC_W] == HADDR[DEC_LSB +: DEC_W])) begin
                dec_hit = 1'b1;
                dec_idx = SEL_W'(i);
                HSEL[i] = 1'b1;
            end
        end
    end

    // Output process: response seen by the master in the current data phase.
    // Unmapped ownership is carried by the FSM state itself (IDLE/DERR*),
    // so dsel only matters in PASS.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = 2'b00;
        HRDATA = '0;
        case (state_q)
            ST_PASS: begin
                for (int i = 0; i < NUM_SLAVES; i++) begin
                    if (dsel_q == SEL_W'(i)) begin
                        HREADY = S_HREADYOUT[i];
                        HRDATA = S_HRDATA[i*DATA_W +: DATA_W];
                        HRESP  = S_HRESP[i*2 +: 2];
                    end
                end
            end
            ST_DERR1, ST_TO1: begin
                HREADY = 1'b0;
                HRESP  = 2'b01;
            end
            ST_DERR2, ST_TO2: begin
                HREADY = 1'b1;
                HRESP  = 2'b01;
            end
            default: ;
        endcase
    end

    // Watchdog fires on the TIMEOUT-th wait cycle of an active data phase.
    always_comb begin
        wd_fire = 1'b0;
        if (TIMEOUT != 0) begin
            wd_fire = (state_q == ST_PASS) && dact_q && !HREADY &&
                      (wd_cnt_q == WD_W'(TIMEOUT - 1));
        end
    end

    // Next-state process.
    always_comb begin
        if (dec_hit)
            accept_state = ST_PASS;
        else if (HTRANS[1])
            accept_state = ST_DERR1;
        else
            accept_state = ST_IDLE;

        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DERR2, ST_TO2: begin
                if (HREADY) state_d = accept_state;
            end
            ST_PASS: begin
                if (HREADY)       state_d = accept_state;
                else if (wd_fire) state_d = ST_TO1;
            end
            ST_DERR1: state_d = ST_DERR2;
            ST_TO1:   state_d = ST_TO2;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Data-phase registers, watchdog, timeout capture and error counter.
    always_comb begin
        dsel_d    = dsel_q;
        dact_d    = dact_q;
        daddr_d   = daddr_q;
        wd_cnt_d  = wd_cnt_q;
        to_flag_d = to_flag_q;
        to_addr_d = to_addr_q;
        err_cnt_d = err_cnt_q;

        if (HREADY) begin
            dsel_d  = dec_idx;
            dact_d  = HTRANS[1];
            daddr_d = HADDR;
        end

        if (HREADY || wd_fire)
            wd_cnt_d = '0;
        else if ((state_q == ST_PASS) && dact_q)
            wd_cnt_d = wd_cnt_q + 1'b1;

        // A new timeout takes priority over a coincident clear.
        if (to_clr)
            to_flag_d = 1'b0;
        if (wd_fire) begin
            to_flag_d = 1'b1;
            to_addr_d = daddr_q;
        end

        if (HREADY && (HRESP == 2'b01) && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + 1'b1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dsel_q    <= '0;
            dact_q    <= 1'b0;
            daddr_q   <= '0;
            wd_cnt_q  <= '0;
            to_flag_q <= 1'b0;
            to_addr_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            dsel_q    <= dsel_d;
            dact_q    <= dact_d;
            daddr_q   <= daddr_d;
            wd_cnt_q  <= wd_cnt_d;
            to_flag_q <= to_flag_d;
            to_addr_q <= to_addr_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign timeout_flag = to_flag_q;
    assign timeout_addr = to_addr_q;
    assign err_cnt      = err_cnt_q;
    assign dbg_state    = state_q;

endmodule
